// File: rtl/unet_ip_pkg.sv
// Shared widths, typedefs and FSM encoding for the UNet upsample block.
package unet_ip_pkg;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 15;
    localparam int DIM_W  = 7;
    localparam int SCL_W  = 3;
    localparam int HW_W   = 2 * DIM_W;
    localparam int PROD_W = 3 * DIM_W + 2 * SCL_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [DIM_W-1:0]  dim_t;
    typedef logic [SCL_W-1:0]  scl_t;
    typedef logic [HW_W-1:0]   hw_t;
    typedef logic [PROD_W-1:0] prod_t;

    // Largest job that still fits the output RAM.
    localparam prod_t MAX_WORDS = prod_t'(1) << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_FLUSH,
        ST_FIN
    } state_t;

    // Output word count at full width so an oversized job cannot alias small.
    function automatic prod_t job_words(dim_t ch, dim_t h, dim_t w, scl_t s);
        return prod_t'(ch) * prod_t'(h) * prod_t'(w) * prod_t'(s) * prod_t'(s);
    endfunction

endpackage

// File: rtl/unet_ip_upsample_addrgen.sv
// Read-address generator: walks the output raster (c, oy, ox) and maps each
// output pixel back to its source pixel in the input map.
module unet_ip_upsample_addrgen
    import unet_ip_pkg::*;
(
    input  logic  clk,
    input  logic  arst_n,
    input  logic  init,
    input  logic  step,
    input  dim_t  channels,
    input  dim_t  height,
    input  dim_t  width,
    input  scl_t  scale,
    input  hw_t   hw,
    output addr_t radr,
    output logic  last
);

    dim_t  c, iy, ix;
    scl_t  sy, sx;
    addr_t plane_base, row_base;

    logic sx_end, ix_end, sy_end, iy_end, c_end;

    // Wrap conditions for each nested counter.
    always_comb begin
        sx_end = (sx == scale - scl_t'(1));
        ix_end = (ix == width - dim_t'(1));
        sy_end = (sy == scale - scl_t'(1));
        iy_end = (iy == height - dim_t'(1));
        c_end  = (c == channels - dim_t'(1));
        last   = c_end && iy_end && sy_end && ix_end && sx_end;
        radr   = plane_base + row_base + addr_t'(ix);
    end

    // Nested counters; row_base only advances once a row has been repeated s times.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            c          <= '0;
            iy         <= '0;
            ix         <= '0;
            sy         <= '0;
            sx         <= '0;
            plane_base <= '0;
            row_base   <= '0;
        end else if (init) begin
            c          <= '0;
            iy         <= '0;
            ix         <= '0;
            sy         <= '0;
            sx         <= '0;
            plane_base <= '0;
            row_base   <= '0;
        end else if (step) begin
            if (!sx_end) begin
                sx <= sx + scl_t'(1);
            end else begin
                sx <= '0;
                if (!ix_end) begin
                    ix <= ix + dim_t'(1);
                end else begin
                    ix <= '0;
                    if (!sy_end) begin
                        sy <= sy + scl_t'(1);
                    end else begin
                        sy <= '0;
                        if (!iy_end) begin
                            iy       <= iy + dim_t'(1);
                            row_base <= row_base + addr_t'(width);
                        end else begin
                            iy         <= '0;
                            row_base   <= '0;
                            c          <= c + dim_t'(1);
                            plane_base <= plane_base + addr_t'(hw);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/unet_ip_upsample.sv
// Nearest-neighbour 2-D upsampler: control FSM, config check and write pipeline.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; config inputs latched on start
// ST_CHECK | one cycle: validate config, precompute H*W
// ST_RUN   | one read per cycle; write trails the read by one cycle
// ST_FLUSH | final write of the pipeline, no read
// ST_FIN   | one-cycle done / triosy strobes, then back to idle
module unet_ip_upsample
    import unet_ip_pkg::*;
(
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [DIM_W-1:0]  channels,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  width,
    input  logic [SCL_W-1:0]  scale,
    output logic [ADDR_W-1:0] input_rsc_radr,
    output logic              input_rsc_re,
    input  logic [DATA_W-1:0] input_rsc_q,
    output logic              input_rsc_clken,
    output logic              input_triosy_lz,
    output logic [ADDR_W-1:0] output_rsc_wadr,
    output logic [DATA_W-1:0] output_rsc_d,
    output logic              output_rsc_we,
    output logic              output_rsc_clken,
    output logic              output_triosy_lz
);

    state_t state, state_nxt;
    dim_t   cfg_ch, cfg_h, cfg_w;
    scl_t   cfg_s;
    hw_t    hw_q;
    logic   err_q;
    logic   we_q;
    addr_t  wadr_q;
    addr_t  oadr;
    addr_t  gen_radr;
    logic   gen_last;
    logic   accept;
    logic   reject;
    logic   re;

    assign accept = (state == ST_IDLE) && start;

    // Config is rejected when any dimension is zero or the result overflows the output RAM.
    always_comb begin
        reject = (cfg_ch == '0) || (cfg_h == '0) || (cfg_w == '0) || (cfg_s == '0) ||
                 (job_words(cfg_ch, cfg_h, cfg_w, cfg_s) > MAX_WORDS);
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        re        = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy      = 1'b1;
                state_nxt = reject ? ST_FIN : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                re   = 1'b1;
                if (gen_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                state_nxt = ST_FIN;
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Config latch, H*W precompute and sticky error flag.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cfg_ch <= '0;
            cfg_h  <= '0;
            cfg_w  <= '0;
            cfg_s  <= '0;
            hw_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                cfg_ch <= channels;
                cfg_h  <= height;
                cfg_w  <= width;
                cfg_s  <= scale;
                err_q  <= 1'b0;
            end
            if (state == ST_CHECK) begin
                hw_q <= hw_t'(cfg_h) * hw_t'(cfg_w);
                if (reject) err_q <= 1'b1;
            end
        end
    end

    // Write pipeline: the write address is the read-side counter delayed one stage.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            oadr   <= '0;
            wadr_q <= '0;
            we_q   <= 1'b0;
        end else begin
            we_q <= re;
            if (accept) begin
                oadr <= '0;
            end else if (re) begin
                oadr   <= oadr + addr_t'(1);
                wadr_q <= oadr;
            end
        end
    end

    unet_ip_upsample_addrgen u_addrgen (
        .clk      (clk),
        .arst_n   (arst_n),
        .init     (state == ST_CHECK),
        .step     (re),
        .channels (cfg_ch),
        .height   (cfg_h),
        .width    (cfg_w),
        .scale    (cfg_s),
        .hw       (hw_q),
        .radr     (gen_radr),
        .last     (gen_last)
    );

    assign err              = err_q;
    assign input_rsc_re     = re;
    assign input_rsc_radr   = re ? gen_radr : '0;
    assign input_rsc_clken  = busy;
    assign output_rsc_clken = busy;
    assign output_rsc_we    = we_q;
    assign output_rsc_wadr  = wadr_q;
    assign output_rsc_d     = we_q ? input_rsc_q : '0;
    assign input_triosy_lz  = done;
    assign output_triosy_lz = done;

endmodule

// File: tb/tb_unet_ip_upsample.sv
// Directed bench for unet_ip_upsample with behavioural input RAM and write monitor.
module tb_unet_ip_upsample;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [6:0]  channels = '0, height = '0, width = '0;
    logic [2:0]  scale = '0;
    logic [14:0] input_rsc_radr, output_rsc_wadr;
    logic        input_rsc_re, input_rsc_clken, input_triosy_lz;
    logic [11:0] input_rsc_q = '0;
    logic [11:0] output_rsc_d;
    logic        output_rsc_we, output_rsc_clken, output_triosy_lz;

    int total = 0;
    int bad = 0;

    logic [11:0] mem_in [0:32767];

    // monitor state
    logic        clr = 1'b0;
    int          cyc = 0;
    int          st_cyc, first_we_cyc, last_we_cyc, done_cyc;
    int          wr_n, re_n, done_n, itri_n, otri_n, seq_err;
    logic [11:0] wr_d [0:255];

    always #5 clk = ~clk;

    unet_ip_upsample dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .channels         (channels),
        .height           (height),
        .width            (width),
        .scale            (scale),
        .input_rsc_radr   (input_rsc_radr),
        .input_rsc_re     (input_rsc_re),
        .input_rsc_q      (input_rsc_q),
        .input_rsc_clken  (input_rsc_clken),
        .input_triosy_lz  (input_triosy_lz),
        .output_rsc_wadr  (output_rsc_wadr),
        .output_rsc_d     (output_rsc_d),
        .output_rsc_we    (output_rsc_we),
        .output_rsc_clken (output_rsc_clken),
        .output_triosy_lz (output_triosy_lz)
    );

    // Synchronous-read input RAM: data appears the cycle after re.
    always @(posedge clk) begin
        if (input_rsc_re) input_rsc_q <= mem_in[input_rsc_radr];
    end

    // Traffic monitor, sampled at the rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (clr) begin
            st_cyc = -1; first_we_cyc = -1; last_we_cyc = -1; done_cyc = -1;
            wr_n = 0; re_n = 0; done_n = 0; itri_n = 0; otri_n = 0; seq_err = 0;
        end else begin
            if (start && !busy && arst_n) st_cyc = cyc;
            if (input_rsc_re) re_n = re_n + 1;
            if (output_rsc_we) begin
                if (first_we_cyc < 0) first_we_cyc = cyc;
                last_we_cyc = cyc;
                if (int'(output_rsc_wadr) != wr_n) seq_err = seq_err + 1;
                if (wr_n < 256) wr_d[wr_n] = output_rsc_d;
                wr_n = wr_n + 1;
            end
            if (done) begin
                done_n = done_n + 1;
                done_cyc = cyc;
            end
            if (input_triosy_lz) itri_n = itri_n + 1;
            if (output_triosy_lz) otri_n = otri_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic start_job(input int ch, input int h, input int w, input int s);
        @(negedge clk);
        channels = 7'(ch);
        height   = 7'(h);
        width    = 7'(w);
        scale    = 3'(s);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_n != 0) break;
        end
        chk(tag, (done_n != 0), 1);
    endtask

    initial begin
        int exp1 [16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};
        int nbad;
        int n_at_rst;

        for (int i = 0; i < 32768; i++) mem_in[i] = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, done, err, input_rsc_re, output_rsc_we, input_rsc_clken,
                         output_rsc_clken, input_triosy_lz, output_triosy_lz}, 0);
        chk("rst_radr", input_rsc_radr, 0);
        chk("rst_wadr", output_rsc_wadr, 0);
        chk("rst_d", output_rsc_d, 0);
        arst_n = 1'b1;

        // 1x2x2 scale 2
        mem_in[0] = 12'd10; mem_in[1] = 12'd20; mem_in[2] = 12'd30; mem_in[3] = 12'd40;
        clear_mon();
        start_job(1, 2, 2, 2);
        chk("t1_busy", busy, 1);
        chk("t1_clken", {input_rsc_clken, output_rsc_clken}, 3);
        wait_done("t1_done_seen", 200);
        repeat (3) @(negedge clk);
        chk("t1_writes", wr_n, 16);
        chk("t1_seq", seq_err, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_d%0d", i), wr_d[i], exp1[i]);
        chk("t1_done_after_last_we", done_cyc - last_we_cyc, 1);
        chk("t1_done_count", done_n, 1);
        chk("t1_triosy", {itri_n[7:0], otri_n[7:0]}, {8'd1, 8'd1});
        chk("t1_err", err, 0);
        chk("t1_busy_after", busy, 0);

        // 2x3x3 scale 1: plain copy
        for (int i = 0; i < 18; i++) mem_in[i] = 12'(i);
        clear_mon();
        start_job(2, 3, 3, 1);
        wait_done("t2_done_seen", 200);
        repeat (3) @(negedge clk);
        chk("t2_writes", wr_n, 18);
        chk("t2_reads", re_n, 18);
        chk("t2_seq", seq_err, 0);
        nbad = 0;
        for (int i = 0; i < 18; i++) if (wr_d[i] !== 12'(i)) nbad++;
        chk("t2_data", nbad, 0);
        chk("t2_first_we_latency", first_we_cyc - st_cyc, 3);

        // oversized job rejected
        clear_mon();
        start_job(64, 32, 32, 2);
        wait_done("t3_done_seen", 50);
        repeat (3) @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_reads", re_n, 0);
        chk("t3_writes", wr_n, 0);
        chk("t3_done_latency", done_cyc - st_cyc, 2);

        // zero scale, then zero height, then a valid job clears err
        clear_mon();
        start_job(1, 2, 2, 0);
        wait_done("t4a_done_seen", 50);
        @(negedge clk);
        chk("t4a_err", err, 1);
        chk("t4a_traffic", re_n + wr_n, 0);
        clear_mon();
        start_job(1, 0, 2, 2);
        wait_done("t4b_done_seen", 50);
        @(negedge clk);
        chk("t4b_err", err, 1);
        chk("t4b_traffic", re_n + wr_n, 0);
        mem_in[0] = 12'd77;
        clear_mon();
        start_job(1, 1, 1, 3);
        chk("t4c_err_cleared", err, 0);
        wait_done("t4c_done_seen", 100);
        repeat (3) @(negedge clk);
        chk("t4c_writes", wr_n, 9);
        nbad = 0;
        for (int i = 0; i < 9; i++) if (wr_d[i] !== 12'd77) nbad++;
        chk("t4c_data", nbad, 0);
        chk("t4c_err_after", err, 0);

        // start pulse while running is ignored
        for (int i = 0; i < 16; i++) mem_in[i] = 12'(100 + i);
        clear_mon();
        start_job(1, 4, 4, 2);
        repeat (20) @(negedge clk);
        channels = 7'd1; height = 7'd1; width = 7'd1; scale = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done_seen", 300);
        repeat (15) @(negedge clk);
        chk("t5_writes", wr_n, 64);
        chk("t5_done_count", done_n, 1);
        chk("t5_seq", seq_err, 0);
        nbad = 0;
        for (int o = 0; o < 64; o++) begin
            int oy, ox;
            oy = o / 8;
            ox = o % 8;
            if (wr_d[o] !== 12'(100 + (oy / 2) * 4 + ox / 2)) nbad++;
        end
        chk("t5_data", nbad, 0);

        // reset mid-run
        clear_mon();
        start_job(1, 4, 4, 2);
        repeat (10) @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", {busy, done, err, input_rsc_re, output_rsc_we, input_rsc_clken,
                            output_rsc_clken, input_triosy_lz, output_triosy_lz}, 0);
        chk("t6_rst_wadr", output_rsc_wadr, 0);
        chk("t6_rst_radr", input_rsc_radr, 0);
        chk("t6_rst_d", output_rsc_d, 0);
        n_at_rst = wr_n;
        chk("t6_was_writing", (n_at_rst > 0), 1);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_writes_after", wr_n, n_at_rst);
        chk("t6_no_done", done_n, 0);
        chk("t6_idle", busy, 0);

        for (int i = 0; i < 18; i++) mem_in[i] = 12'(i);
        clear_mon();
        start_job(2, 3, 3, 1);
        wait_done("t6_fresh_done_seen", 200);
        repeat (3) @(negedge clk);
        chk("t6_fresh_writes", wr_n, 18);
        chk("t6_fresh_seq", seq_err, 0);
        nbad = 0;
        for (int i = 0; i < 18; i++) if (wr_d[i] !== 12'(i)) nbad++;
        chk("t6_fresh_data", nbad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unet_ip_upsample.md
Name: unet_ip_upsample

Overview:
Nearest-neighbour 2-D upsampler for the UNet decoder path; the inverse counterpart of the encoder max-pool stage. Reads a CHW feature map from a single-port input RAM and writes a CHW map enlarged by an integer scale factor to an output RAM. Runs at one output pixel per cycle with start/done handshake and Catapult-style triosy completion strobes.

Parameters:
DATA_W, 12, pixel word width
ADDR_W, 15, RAM address width (both RAMs, 32768 words)
DIM_W, 7, width of channels/height/width config inputs
SCL_W, 3, width of scale input

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches config when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end
err  out  1  sticky until next accepted start; config rejected
channels  in  DIM_W  feature-map channels
height  in  DIM_W  input height H
width  in  DIM_W  input width W
scale  in  SCL_W  upsample factor s (valid 1..7)
input_rsc_radr  out  ADDR_W  input RAM read address
input_rsc_re  out  1  input RAM read enable
input_rsc_q  in  DATA_W  read data, valid one cycle after re
input_rsc_clken  out  1  input RAM clock enable
input_triosy_lz  out  1  input-done strobe
output_rsc_wadr  out  ADDR_W  output RAM write address
output_rsc_d  out  DATA_W  write data
output_rsc_we  out  1  write enable
output_rsc_clken  out  1  output RAM clock enable
output_triosy_lz  out  1  output-done strobe

Behaviour:
- Reset (arst_n low, async): state IDLE; all outputs 0; counters and latched config 0.
- FSM IDLE -> CHECK -> RUN -> FLUSH -> FIN -> IDLE.
- IDLE: start=1 latches channels/height/width/scale, clears err, busy=1, go CHECK. start ignored in all other states.
- CHECK (1 cycle): reject if any of channels, H, W, s is 0, or channels*H*W*s*s > 2^ADDR_W (compute at 27 bits, no truncation). Reject: err=1, go FIN with no RAM traffic. Else compute HW=H*W (14 bits), go RUN.
- RUN: traverse output in order c, oy, ox (ox fastest). Counters: c, iy, sy, ix, sx. Each cycle: re=1, radr = plane_base + row_base + ix, where plane_base += HW per channel, row_base += W per input row; sx advances 0..s-1, then ix increments; at end of row, sy advances, and row_base steps only when sy wraps. Output address is a free-running counter from 0, +1 per write.
- Pipeline: read issued cycle t; cycle t+1 we=1, d=input_rsc_q, wadr=address counter delayed one stage. Latency 2 cycles from RUN entry to first write. Exactly channels*H*W*s*s writes, contiguous addresses 0..N-1.
- After last read issue go FLUSH (1 cycle, final write only, re=0).
- FIN: done=1, input_triosy_lz=1, output_triosy_lz=1 for one cycle, busy=0; go IDLE.
- clken for each RAM = 1 while busy, 0 otherwise.
- s=1: plain copy, N = channels*H*W.
- Reset mid-job: abandon immediately; no further writes; done not pulsed.
- Only input_rsc_q is used combinationally (registered path into d is allowed; latency must stay 2).

Decomposition:
- Package unet_ip_pkg: DATA_W, ADDR_W, DIM_W, SCL_W, FSM state enum, address/dim typedefs.
- One sub-module unet_ip_upsample_addrgen: counters and radr/last-flag generation; top holds FSM, config check, write pipeline.

Test Plan:
- ch=1,H=2,W=2,s=2, input [10,20,30,40] -> 16 writes at wadr 0..15: 10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40; done one cycle after last write.
- ch=2,H=3,W=3,s=1, input 0..17 -> output identical 0..17; first we 2 cycles after RUN entry; 18 writes.
- ch=64,H=32,W=32,s=2 (262144 > 32768) -> err=1, zero re/we, done pulse 2 cycles after start.
- scale=0 or height=0 -> err=1, no RAM traffic; next valid start clears err.
- Start pulse during RUN of ch=1,H=4,W=4,s=2 -> ignored; exactly 64 writes, single done.
- arst_n low for 1 cycle mid-RUN -> all outputs 0 same cycle, state IDLE, no done; fresh start completes normally.
